// File: rtl/mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_seq_pkg
// Shared types and constants for the sequenced 8x8 multiplier.
//   mult_seq_state_t : controller states, in sequencing order
//   SH_LL/SH_MID/SH_HH : left-shift applied to each nibble partial product
// ---------------------------------------------------------------------------
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_LL = 3'd1,
        S_LH = 3'd2,
        S_HL = 3'd3,
        S_HH = 3'd4,
        DONE = 3'd5
    } mult_seq_state_t;

    localparam logic [3:0] SH_LL  = 4'd0;
    localparam logic [3:0] SH_MID = 4'd4;
    localparam logic [3:0] SH_HH  = 4'd8;

endpackage

// File: rtl/nib_mult_4x4.sv
// ---------------------------------------------------------------------------
// nib_mult_4x4
// Exact, purely combinational 4x4 unsigned multiplier.
// Ports:
//   i_a [3:0] : multiplicand nibble
//   i_b [3:0] : multiplier nibble
//   o_p [7:0] : product i_a * i_b (max 8'hE1, never overflows)
// ---------------------------------------------------------------------------
module nib_mult_4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    assign o_p = {4'h0, i_a} * {4'h0, i_b};

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_8x8_seq_ctrl
// Sequenced 8x8 unsigned multiplier. One 4x4 nibble multiplier is reused
// over four cycles (LL, LH, HL, HH) and its shifted partial products are
// folded into a 16-bit accumulator. Valid/ready on both sides.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operand pair valid
//   in_ready  : high only in IDLE
//   A, B [7:0]: unsigned operands, captured on in_valid && in_ready
//   out_valid : high only in DONE; R holds the finished product
//   out_ready : sink accepts R (only acted on in DONE)
//   R [15:0]  : product, held until the next product completes
//
// Build option:
//   MULT_SEQ_OR_ACC_EN defined   -> partial products combined by bitwise OR
//                                   (approximate, carry-free)
//   MULT_SEQ_OR_ACC_EN undefined -> exact 16-bit addition, R = A*B
// ---------------------------------------------------------------------------
module mult_8x8_seq_ctrl
    import mult_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] R
);

    mult_seq_state_t r_state;
    mult_seq_state_t w_state_next;

    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_res;

    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [3:0]  w_sh;
    logic [7:0]  w_p;
    logic [15:0] w_pp_sh;
    logic [15:0] w_acc_next;

    // Combine an accumulated value with a shifted partial product.
    function automatic logic [15:0] acc_combine(input logic [15:0] acc,
                                                input logic [15:0] pp);
`ifdef MULT_SEQ_OR_ACC_EN
        return acc | pp;
`else
        return acc + pp;
`endif
    endfunction

    nib_mult_4x4 u_nib_mult (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_p)
    );

    // Nibble selection and shift amount for the partial product of this state.
    always_comb begin
        w_nib_a = 4'h0;
        w_nib_b = 4'h0;
        w_sh    = SH_LL;
        case (r_state)
            S_LL: begin w_nib_a = r_a[3:0]; w_nib_b = r_b[3:0]; w_sh = SH_LL;  end
            S_LH: begin w_nib_a = r_a[3:0]; w_nib_b = r_b[7:4]; w_sh = SH_MID; end
            S_HL: begin w_nib_a = r_a[7:4]; w_nib_b = r_b[3:0]; w_sh = SH_MID; end
            S_HH: begin w_nib_a = r_a[7:4]; w_nib_b = r_b[7:4]; w_sh = SH_HH;  end
            default: ;
        endcase
    end

    assign w_pp_sh = {8'h00, w_p} << w_sh;

    // S_LL starts a fresh accumulation so no stale value from the previous
    // product can leak in.
    assign w_acc_next = (r_state == S_LL) ? w_pp_sh : acc_combine(r_acc, w_pp_sh);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = S_LL;
            S_LL:    w_state_next = S_LH;
            S_LH:    w_state_next = S_HL;
            S_HL:    w_state_next = S_HH;
            S_HH:    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 8'h00;
            r_b   <= 8'h00;
            r_acc <= 16'h0000;
            r_res <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= A;
                        r_b <= B;
                    end
                end
                S_LL, S_LH, S_HL: r_acc <= w_acc_next;
                // The result register is loaded only with a complete product,
                // so R never shows a partial sum.
                S_HH: begin
                    r_acc <= w_acc_next;
                    r_res <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign R         = r_res;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
module tb_mult_8x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] R;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_8x8_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Product as the spec defines it: exact A*B, or the OR of the four
    // shifted nibble partial products in the carry-free build.
    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_OR_ACC_EN
        int ll, lh, hl, hh;
        ll = a[3:0] * b[3:0];
        lh = a[3:0] * b[7:4];
        hl = a[7:4] * b[3:0];
        hh = a[7:4] * b[7:4];
        return 16'(ll | (lh << 4) | (hl << 4) | (hh << 8));
`else
        return 16'(int'(a) * int'(b));
`endif
    endfunction

    // Timing model: accept in idle, four busy cycles, then done until out_ready.
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_exp  = 16'h0;
    logic [15:0] m_R    = 16'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_R    <= 16'h0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_R    <= m_exp;
            end
        end else if (in_valid) begin
            m_exp <= model_prod(A, B);
            m_cnt <= 4;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_in_ready", {31'b0, in_ready}, {31'b0, (!m_done && m_cnt == 0)});
            check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_done});
            if (m_done) check("cyc_R", {16'b0, R}, {16'b0, m_R});
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        check("wait_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int hold);
        int lat;
        wait_ready();
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = b + 8'd1;          // operands must already be private copies
        wait_valid(lat);
        check({name, "_latency"}, lat, 32'd4);
        check({name, "_R"}, {16'b0, R}, {16'b0, exp});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({name, "_hold_R"}, {16'b0, R}, {16'b0, exp});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, {31'b0, out_valid}, 32'd0);
        check({name, "_post_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] exp_ff, exp_1234;
`ifdef MULT_SEQ_OR_ACC_EN
        exp_ff   = 16'hEFF1;
        exp_1234 = 16'h0368;
`else
        exp_ff   = 16'hFE01;
        exp_1234 = 16'h03A8;
`endif
        // Literal values pin the model itself.
        check("model_ff", {16'b0, model_prod(8'hFF, 8'hFF)}, {16'b0, exp_ff});
        check("model_1234", {16'b0, model_prod(8'h12, 8'h34)}, {16'b0, exp_1234});

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_R", {16'b0, R}, 32'd0);
        rst = 1'b0;

        run_op("ffff", 8'hFF, 8'hFF, exp_ff, 0);
        run_op("x1234", 8'h12, 8'h34, exp_1234, 2);

        // Reset while in S_HL: abort, nothing partial ever shown.
        wait_ready();
        A = 8'hFF; B = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_R", {16'b0, R}, 32'd0);
        @(posedge clk); #1;
        check("midrst_next_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_next_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        run_op("x0305", 8'h03, 8'h05, 16'h000F, 0);

        // Backpressure with in_valid held high throughout.
        wait_ready();
        A = 8'h00; B = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_accepted", {31'b0, in_ready}, 32'd0);
        wait_valid(lat);
        check("bp_latency", lat, 32'd4);
        for (int k = 0; k < 5; k++) begin
            check("bp_R", {16'b0, R}, 32'd0);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        check("bp_R_last", {16'b0, R}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_after_hs", {31'b0, in_ready}, 32'd1);
        check("bp_valid_after_hs", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check("bp_second_accept", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp2_latency", lat, 32'd4);
        check("bp2_R", {16'b0, R}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp2_post_ready", {31'b0, in_ready}, 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
